// File: rtl/fp32_pkg.sv
// Shared binary32 definitions: field widths, canonical quiet NaN, unpacked operand
// struct and the adder FSM state type.
package fp32_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int BIAS   = 127;
    localparam int SIG_W  = FRAC_W + 1;   // significand with hidden bit
    localparam int EXT_W  = SIG_W + 3;    // plus guard, round, sticky

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [SIG_W-1:0] sig;
    } fp_unpacked_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ALIGN   = 2'd1,
        ADDNORM = 2'd2
    } state_t;

    // Zero exponent field flushes to signed zero; neg flips the sign (used for subtract).
    function automatic fp_unpacked_t fp_unpack(input logic [31:0] w, input logic neg);
        fp_unpacked_t u;
        u.sign = w[31] ^ neg;
        u.exp  = w[30:23];
        u.sig  = (w[30:23] == '0) ? '0 : {1'b1, w[22:0]};
        return u;
    endfunction

endpackage

// File: rtl/lzc24.sv
// Combinational leading-zero counter over the 27-bit extended significand
// (24-bit significand plus guard/round/sticky). All-zero input returns 27.
module lzc24
    import fp32_pkg::*;
(
    input  logic [EXT_W-1:0] d,
    output logic [4:0]       cnt
);

    // Scan upward so the highest set bit makes the final assignment.
    always_comb begin
        cnt = 5'd27;
        for (int i = 0; i < EXT_W; i++) begin
            if (d[i]) cnt = 5'(EXT_W - 1 - i);
        end
    end

endmodule

// File: rtl/addition_stage32.sv
// Two-step pipelined binary32 adder/subtractor: the load edge captures operands,
// ALIGN swaps and shifts, ADDNORM adds/subtracts, normalises and truncates.
module addition_stage32
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic        PlusOrMinus,
    input  logic        cin,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] sumFinal,
    output logic        cout,
    output logic        ready
);

    state_t state, state_n;

    // operand capture
    logic [31:0] a_reg, b_reg;
    logic        op_reg, cin_reg;

    // aligned operands
    logic [EXT_W-1:0] big_m, small_m;
    logic [EXP_W-1:0] al_exp;
    logic             al_sign, al_sub, al_cin, al_spec;
    logic [31:0]      al_spec_val;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst)     state <= IDLE;
        else if (en) state <= state_n;
    end

    // A load in any state restarts; the load edge itself captures operands.
    always_comb begin
        state_n = state;
        if (load) begin
            state_n = ALIGN;
        end else begin
            case (state)
                ALIGN:   state_n = ADDNORM;
                ADDNORM: state_n = IDLE;
                default: state_n = state;
            endcase
        end
    end

    // ---------------- ALIGN combinational ----------------
    fp_unpacked_t ua, ub, big, sml;
    logic [30:0]  a_mag, b_mag;
    logic [7:0]   dexp;
    logic [53:0]  wide;
    logic [EXT_W-1:0] sm_al;
    logic         a_nan, b_nan, a_inf, b_inf;
    logic         spec_n;
    logic [31:0]  spec_val_n;

    always_comb begin
        ua = fp_unpack(a_reg, 1'b0);
        ub = fp_unpack(b_reg, op_reg);
        a_mag = (ua.exp == '0) ? 31'd0 : a_reg[30:0];
        b_mag = (ub.exp == '0) ? 31'd0 : b_reg[30:0];
        if (a_mag >= b_mag) begin
            big = ua;
            sml = ub;
        end else begin
            big = ub;
            sml = ua;
        end
        dexp = big.exp - sml.exp;
        wide = {sml.sig, 30'd0} >> dexp;
        // Bits shifted past the sticky position collapse into it.
        if (dexp >= 8'd27) sm_al = {26'd0, |sml.sig};
        else               sm_al = wide[53:27] | {26'd0, |wide[26:0]};

        a_nan = (&a_reg[30:23]) &  (|a_reg[22:0]);
        a_inf = (&a_reg[30:23]) & ~(|a_reg[22:0]);
        b_nan = (&b_reg[30:23]) &  (|b_reg[22:0]);
        b_inf = (&b_reg[30:23]) & ~(|b_reg[22:0]);
        spec_n     = 1'b0;
        spec_val_n = '0;
        if (a_nan | b_nan) begin
            spec_n     = 1'b1;
            spec_val_n = QNAN;
        end else if (a_inf & b_inf) begin
            spec_n     = 1'b1;
            spec_val_n = (ua.sign != ub.sign) ? QNAN : {ua.sign, 8'hFF, 23'd0};
        end else if (a_inf) begin
            spec_n     = 1'b1;
            spec_val_n = {ua.sign, 8'hFF, 23'd0};
        end else if (b_inf) begin
            spec_n     = 1'b1;
            spec_val_n = {ub.sign, 8'hFF, 23'd0};
        end
    end

    // ---------------- ADDNORM combinational ----------------
    logic [EXT_W:0]    sum28;
    logic [EXT_W-1:0]  diff, m;
    logic [4:0]        lz;
    logic signed [9:0] e;
    logic              rc, cancel;
    logic [31:0]       res;
    logic              unused_bits;

    lzc24 u_lzc (
        .d   (diff),
        .cnt (lz)
    );

    always_comb begin
        sum28  = {1'b0, big_m} + {1'b0, small_m} + {27'd0, al_cin};
        diff   = big_m - small_m;
        m      = '0;
        e      = '0;
        rc     = 1'b0;
        cancel = 1'b0;
        if (al_sub) begin
            if (diff == '0) begin
                cancel = 1'b1;
            end else begin
                m = diff << lz;
                e = $signed({2'b00, al_exp}) - $signed({5'd0, lz});
            end
        end else if (sum28[EXT_W]) begin
            m  = sum28[EXT_W:1];
            e  = $signed({2'b00, al_exp}) + 10'sd1;
            rc = 1'b1;
        end else begin
            m = sum28[EXT_W-1:0];
            e = $signed({2'b00, al_exp});
        end

        if (al_spec) begin
            res = al_spec_val;
            rc  = 1'b0;
        end else if (cancel) begin
            res = 32'd0;
        end else if (e >= 10'sd255) begin
            res = {al_sign, 8'hFF, 23'd0};
        end else if (e <= 10'sd0) begin
            res = {al_sign, 31'd0};
        end else begin
            res = {al_sign, e[7:0], m[25:3]};
        end
    end

    // hidden bit and G/R/S are dropped by truncation
    assign unused_bits = ^{m[26], m[2:0]};

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg       <= '0;
            b_reg       <= '0;
            op_reg      <= 1'b0;
            cin_reg     <= 1'b0;
            big_m       <= '0;
            small_m     <= '0;
            al_exp      <= '0;
            al_sign     <= 1'b0;
            al_sub      <= 1'b0;
            al_cin      <= 1'b0;
            al_spec     <= 1'b0;
            al_spec_val <= '0;
            sumFinal    <= '0;
            cout        <= 1'b0;
            ready       <= 1'b0;
        end else if (en) begin
            if (load) begin
                a_reg   <= A;
                b_reg   <= B;
                op_reg  <= PlusOrMinus;
                cin_reg <= cin;
                ready   <= 1'b0;
            end else if (state == ALIGN) begin
                big_m       <= {big.sig, 3'b000};
                small_m     <= sm_al;
                al_exp      <= big.exp;
                al_sign     <= big.sign;
                al_sub      <= ua.sign ^ ub.sign;
                al_cin      <= cin_reg;
                al_spec     <= spec_n;
                al_spec_val <= spec_val_n;
            end else if (state == ADDNORM) begin
                sumFinal <= res;
                cout     <= rc;
                ready    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_addition_stage32.sv
// Scoreboard bench for addition_stage32: expected results are queued at load time
// and popped when ready rises.
module tb_addition_stage32;

    logic        clk = 1'b0;
    logic        rst, en, load, PlusOrMinus, cin;
    logic [31:0] A, B;
    logic [31:0] sumFinal;
    logic        cout, ready;

    addition_stage32 dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .load        (load),
        .PlusOrMinus (PlusOrMinus),
        .cin         (cin),
        .A           (A),
        .B           (B),
        .sumFinal    (sumFinal),
        .cout        (cout),
        .ready       (ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] s;
        logic        c;
    } exp_t;

    typedef struct {
        logic [31:0] a, b;
        logic        op, ci;
        logic [31:0] s;
        logic        c;
    } vec_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] last_s   = 32'd0;
    logic        last_c   = 1'b0;

    function automatic vec_t mkv(input logic [31:0] a, input logic [31:0] b, input logic op,
                                 input logic ci, input logic [31:0] s, input logic c);
        vec_t v;
        v.a = a; v.b = b; v.op = op; v.ci = ci; v.s = s; v.c = c;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic op,
                         input logic ci, input logic [31:0] es, input logic ec, input bit push);
        exp_t x;
        A = a; B = b; PlusOrMinus = op; cin = ci; load = 1'b1;
        if (push) begin
            x.s = es; x.c = ec;
            sb.push_back(x);
        end
        tick();
        load = 1'b0;
    endtask

    task automatic wait_ready(output int edges, output bit ok);
        edges = 0;
        ok    = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            edges++;
            if (ready) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_table(input string tag, input vec_t t[$]);
        int   edges;
        bit   ok;
        exp_t x;
        foreach (t[i]) begin
            issue(t[i].a, t[i].b, t[i].op, t[i].ci, t[i].s, t[i].c, 1'b1);
            checks++;
            if (ready !== 1'b0) begin
                failures++;
                $display("FAIL %s[%0d] ready_clear got=%b want=0", tag, i, ready);
            end
            wait_ready(edges, ok);
            checks++;
            if (!ok || edges != 2) begin
                failures++;
                $display("FAIL %s[%0d] latency got=%0d ok=%0d want=2", tag, i, edges, ok);
            end
            if (sb.size() > 0) begin
                x = sb.pop_front();
                last_s = x.s;
                last_c = x.c;
                checks++;
                if (sumFinal !== x.s) begin
                    failures++;
                    $display("FAIL %s[%0d] sum got=%h want=%h", tag, i, sumFinal, x.s);
                end
                checks++;
                if (cout !== x.c) begin
                    failures++;
                    $display("FAIL %s[%0d] cout got=%b want=%b", tag, i, cout, x.c);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; load = 1'b1; PlusOrMinus = 1'b0; cin = 1'b0;
        A = 32'h40D8_0000; B = 32'h4040_0000;
        tick();
        tick();
        checks++;
        if (sumFinal !== 32'd0 || cout !== 1'b0 || ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got=%h/%b/%b want=0/0/0", sumFinal, cout, ready);
        end
        rst = 1'b0; load = 1'b0;
        repeat (4) tick();
        checks++;
        if (ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle ready got=%b want=0", ready);
        end
    endtask

    task automatic test_add_sub();
        vec_t t[$];
        t.push_back(mkv(32'h40D8_0000, 32'h4040_0000, 1'b0, 1'b0, 32'h411C_0000, 1'b1));
        t.push_back(mkv(32'h40D8_0000, 32'hC040_0000, 1'b0, 1'b0, 32'h4070_0000, 1'b0));
        t.push_back(mkv(32'hC0D8_0000, 32'h4040_0000, 1'b0, 1'b0, 32'hC070_0000, 1'b0));
        t.push_back(mkv(32'h40D8_0000, 32'h4040_0000, 1'b1, 1'b0, 32'h4070_0000, 1'b0));
        t.push_back(mkv(32'h40D8_0000, 32'hC040_0000, 1'b1, 1'b0, 32'h411C_0000, 1'b1));
        t.push_back(mkv(32'hC0D8_0000, 32'h4040_0000, 1'b1, 1'b0, 32'hC11C_0000, 1'b1));
        t.push_back(mkv(32'hC0D8_0000, 32'hC040_0000, 1'b1, 1'b0, 32'hC070_0000, 1'b0));
        // 1.0 - (1 - 2^-24): 24-place renormalisation
        t.push_back(mkv(32'h3F80_0000, 32'h3F7F_FFFF, 1'b1, 1'b0, 32'h3380_0000, 1'b0));
        // GRS = 111 after alignment: cin ripples into the kept fraction
        t.push_back(mkv(32'h3F80_0000, 32'h3E7F_FFFF, 1'b0, 1'b0, 32'h3F9F_FFFF, 1'b0));
        t.push_back(mkv(32'h3F80_0000, 32'h3E7F_FFFF, 1'b0, 1'b1, 32'h3FA0_0000, 1'b0));
        run_table("add_sub", t);
    endtask

    task automatic test_special();
        vec_t t[$];
        t.push_back(mkv(32'h4040_0000, 32'h4040_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b0));
        t.push_back(mkv(32'h7F80_0000, 32'h7F80_0000, 1'b1, 1'b0, 32'h7FC0_0000, 1'b0));
        t.push_back(mkv(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 1'b0, 32'h7F80_0000, 1'b1));
        t.push_back(mkv(32'h7FC0_0001, 32'h3F80_0000, 1'b0, 1'b0, 32'h7FC0_0000, 1'b0));
        t.push_back(mkv(32'h7F80_0000, 32'h4040_0000, 1'b0, 1'b0, 32'h7F80_0000, 1'b0));
        t.push_back(mkv(32'h4040_0000, 32'h7F80_0000, 1'b1, 1'b0, 32'hFF80_0000, 1'b0));
        t.push_back(mkv(32'h3F80_0000, 32'h0040_0000, 1'b0, 1'b0, 32'h3F80_0000, 1'b0));
        t.push_back(mkv(32'h3F80_0000, 32'h3080_0000, 1'b0, 1'b0, 32'h3F80_0000, 1'b0));
        t.push_back(mkv(32'h8080_0001, 32'h8080_0000, 1'b1, 1'b0, 32'h8000_0000, 1'b0));
        run_table("special", t);
    endtask

    task automatic test_en_stall();
        exp_t x;
        issue(32'h40D8_0000, 32'h4040_0000, 1'b0, 1'b0, 32'h411C_0000, 1'b1, 1'b1);
        tick();
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            A = 32'h3F80_0000; B = 32'h3F80_0000; load = 1'b1;
            tick();
            checks++;
            if (ready !== 1'b0 || sumFinal !== last_s || cout !== last_c) begin
                failures++;
                $display("FAIL stall_frozen[%0d] got=%h/%b/%b want=%h/%b/0",
                         i, sumFinal, cout, ready, last_s, last_c);
            end
        end
        load = 1'b0;
        en   = 1'b1;
        tick();
        checks++;
        if (ready !== 1'b1) begin
            failures++;
            $display("FAIL stall_ready got=%b want=1", ready);
        end
        if (sb.size() > 0) begin
            x = sb.pop_front();
            last_s = x.s;
            last_c = x.c;
            checks++;
            if (sumFinal !== x.s || cout !== x.c) begin
                failures++;
                $display("FAIL stall_result got=%h/%b want=%h/%b", sumFinal, cout, x.s, x.c);
            end
        end
        repeat (3) tick();
        checks++;
        if (ready !== 1'b1 || sumFinal !== last_s) begin
            failures++;
            $display("FAIL result_hold got=%h/%b want=%h/1", sumFinal, ready, last_s);
        end
    endtask

    task automatic test_back_to_back();
        int   edges;
        bit   ok;
        exp_t x;
        issue(32'h3F80_0000, 32'h3F80_0000, 1'b0, 1'b0, 32'h4000_0000, 1'b1, 1'b0);
        issue(32'h40D8_0000, 32'h4040_0000, 1'b1, 1'b0, 32'h4070_0000, 1'b0, 1'b1);
        wait_ready(edges, ok);
        checks++;
        if (!ok || edges != 2) begin
            failures++;
            $display("FAIL restart_latency got=%0d ok=%0d want=2", edges, ok);
        end
        if (sb.size() > 0) begin
            x = sb.pop_front();
            last_s = x.s;
            last_c = x.c;
            checks++;
            if (sumFinal !== x.s || cout !== x.c) begin
                failures++;
                $display("FAIL restart_result got=%h/%b want=%h/%b", sumFinal, cout, x.s, x.c);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        issue(32'h40D8_0000, 32'h4040_0000, 1'b0, 1'b0, 32'h411C_0000, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (sumFinal !== 32'd0 || ready !== 1'b0 || cout !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid got=%h/%b/%b want=0/0/0", sumFinal, cout, ready);
        end
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (ready) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_no_ready got=%b want=0", seen);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add_sub();
        test_special();
        test_en_stall();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
